instruction_fetch: RTL and testbench

Producer side of the decoder's instruction input. Keeps the PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small prefetch FIFO and presents them one at a time with instr_valid, which drives the decoder's enable. A branch redirect flushes the FIFO, discards any in-flight read and restarts fetch at the target.

---
 rtl/instruction_fetch.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC, req/ack word reads, and a small prefetch FIFO
// whose registered head feeds the decoder. A branch redirect flushes and refetches.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } state_t;

    state_t        state_r;
    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [31:0]   fifo_word_r [DEPTH];
    logic [31:0]   fifo_pc_r   [DEPTH];

    logic          pop_s;
    logic          push_s;
    logic [CW-1:0] fill_s;
    logic [CW-1:0] count_nxt_s;
    logic [31:0]   word_nxt_s  [DEPTH];
    logic [31:0]   pc_nxt_s    [DEPTH];
    logic [31:0]   pc_inc_s;

    assign pc_inc_s = pc_r + 32'd4;

    // Next FIFO contents: shift-down on pop, then append at the first free slot.
    always_comb begin
        pop_s       = instr_valid && instr_ready && !redirect;
        push_s      = (state_r == ST_REQ) && mem_ack && !redirect;
        fill_s      = count_r;
        count_nxt_s = count_r;
        word_nxt_s  = fifo_word_r;
        pc_nxt_s    = fifo_pc_r;
        if (redirect) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    word_nxt_s[i] = fifo_word_r[i+1];
                    pc_nxt_s[i]   = fifo_pc_r[i+1];
                end
                word_nxt_s[DEPTH-1] = 32'h0000_0000;
                pc_nxt_s[DEPTH-1]   = 32'h0000_0000;
                fill_s              = count_r - ONE_C;
            end else begin
                fill_s = count_r;
            end
            if (push_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == fill_s) begin
                        word_nxt_s[i] = mem_rdata;
                        pc_nxt_s[i]   = pc_r;
                    end else begin
                        word_nxt_s[i] = word_nxt_s[i];
                        pc_nxt_s[i]   = pc_nxt_s[i];
                    end
                end
                count_nxt_s = fill_s + ONE_C;
            end else begin
                count_nxt_s = fill_s;
            end
        end
    end

    // FIFO storage and the registered head presented to the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= {CW{1'b0}};
            instr_valid <= 1'b0;
            instruction <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]   <= 32'h0000_0000;
            end
        end else begin
            count_r     <= count_nxt_s;
            instr_valid <= (count_nxt_s != {CW{1'b0}});
            instruction <= (count_nxt_s != {CW{1'b0}}) ? word_nxt_s[0] : 32'h0000_0000;
            instr_pc    <= (count_nxt_s != {CW{1'b0}}) ? pc_nxt_s[0] : 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word_r[i] <= word_nxt_s[i];
                fifo_pc_r[i]   <= pc_nxt_s[i];
            end
        end
    end

    // Fetch FSM: a request is never withdrawn before its ack; redirect wins its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0000_0000;
        end else if (redirect) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
            case (state_r)
                ST_REQ, ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch_enable && (count_r < DEPTH_C)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc_r;
                        state_r  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        pc_r <= pc_inc_s;
                        if (fetch_enable && (count_nxt_s < DEPTH_C)) begin
                            mem_addr <= pc_inc_s;
                        end else begin
                            mem_req <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, a hand-written reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_enable (fetch_enable),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl [29];

    // Memory contents as a function of address
    function automatic logic [31:0] wf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic fe, input logic ack, input logic rdy,
                                input logic rd, input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic vld, input logic [31:0] ipc);
        vec_t v;
        v.fe = fe; v.ack = ack; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic fe, input logic ack, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
        fetch_enable = fe;
        mem_ack      = ack;
        mem_rdata    = ack ? wf(mem_addr) : $urandom;
        instr_ready  = rdy;
        redirect     = rd;
        redirect_pc  = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ipc, input logic [31:0] ins);
        chk({tag, " mem_req"}, {31'b0, mem_req}, {31'b0, req});
        if (req) chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, vld});
        chk({tag, " instr_pc"}, instr_pc, ipc);
        chk({tag, " instruction"}, instruction, ins);
    endtask

    // Reference model state: buffered {pc, word}, next pc, outstanding read
    logic [63:0] q [$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_out;
    logic        m_disc;

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h104);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h104);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h108);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10C,       1'b1, 32'h108);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h203,       1'b1, 32'h10C,       1'b0, 32'h0);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10C,       1'b0, 32'h0);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h204,       1'b1, 32'h200);
        tbl[17] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h300,       1'b0, 32'h0,         1'b0, 32'h0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h300,       1'b0, 32'h0);
        tbl[19] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h304,       1'b1, 32'h300);
        tbl[20] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h308,       1'b1, 32'h304);
        tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h304);
        tbl[22] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h308);
        tbl[23] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, 32'h0);
        tbl[25] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tbl[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
        tbl[27] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0);
        tbl[28] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);

        rst_n = 1'b0; fetch_enable = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].fe, tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            chk_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld,
                     tbl[i].ipc, tbl[i].vld ? wf(tbl[i].ipc) : 32'h0);
        end

        // Async reset in the middle of an outstanding request with a word buffered
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_outs("rst_seq issue", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_outs("rst_seq push", 1'b1, 32'h8, 1'b1, 32'h4, wf(32'h4));
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rst_seq async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("rst_seq mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_outs("rst_seq restart", 1'b1, RPC, 1'b0, 32'h0, 32'h0);

        // Randomized traffic against the reference model
        rst_n = 1'b0; fetch_enable = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_pc = RPC; m_addr = 32'h0; m_out = 1'b0; m_disc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int          sz0;
            logic        fe, ack, rdy, rd;
            logic [31:0] rpc, rdata;
            fe    = ($urandom_range(0, 9) < 8);
            ack   = m_out && ($urandom_range(0, 1) == 1);
            rdy   = ($urandom_range(0, 9) < 6);
            rd    = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            rdata = $urandom;
            fetch_enable = fe; mem_ack = ack; mem_rdata = rdata;
            instr_ready = rdy; redirect = rd; redirect_pc = rpc;

            sz0 = q.size();
            if (rd) begin
                m_pc = {rpc[31:2], 2'b00};
                q.delete();
                if (m_out && ack) begin
                    m_out = 1'b0; m_disc = 1'b0;
                end else if (m_out) begin
                    m_disc = 1'b1;
                end
            end else begin
                if (sz0 != 0 && rdy) void'(q.pop_front());
                if (m_out) begin
                    if (ack) begin
                        if (m_disc) begin
                            m_out = 1'b0; m_disc = 1'b0;
                        end else begin
                            q.push_back({m_pc, rdata});
                            m_pc = m_pc + 32'd4;
                            if (fe && q.size() < DEPTH) m_addr = m_pc;
                            else m_out = 1'b0;
                        end
                    end
                end else if (fe && sz0 < DEPTH) begin
                    m_out = 1'b1; m_addr = m_pc;
                end
            end

            @(posedge clk);
            @(negedge clk);
            if (q.size() != 0)
                chk_outs($sformatf("rnd%0d", c), m_out, m_addr, 1'b1, q[0][63:32], q[0][31:0]);
            else
                chk_outs($sformatf("rnd%0d", c), m_out, m_addr, 1'b0, 32'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
